conv_layer_mem: RTL

CONV_LAYER_MEM -- requirements
Module: conv_layer_mem

---
 rtl/conv_layer_mem.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/conv_layer_mem.sv
// Two-bank (L0/L1) conv feature memory: zero-latency CPU read/write port plus a bank dump stream.
// Dump words are registered one cycle after start/accept; dump_ready low holds dump_addr/dump_data.
module conv_layer_mem #(
  parameter int DW       = 20,
  parameter int L0_DEPTH = 4096,
  parameter int L1_DEPTH = 1024
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          busy,
  input  logic          cwr,
  input  logic [11:0]   caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic          crd,
  input  logic [11:0]   caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic [2:0]    csel,
  input  logic          dump_start,
  input  logic [2:0]    dump_sel,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [11:0]   dump_addr,
  output logic [DW-1:0] dump_data,
  output logic          dump_done,
  output logic          err
);

  localparam int AW0 = $clog2(L0_DEPTH);
  localparam int AW1 = $clog2(L1_DEPTH);
  localparam logic [2:0] SEL_L0 = 3'b001;
  localparam logic [2:0] SEL_L1 = 3'b011;

  typedef enum logic [1:0] {IDLE, DUMP, DONE} state_t;

  logic [DW-1:0] r_l0 [L0_DEPTH];
  logic [DW-1:0] r_l1 [L1_DEPTH];

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_dsel_l1;
  logic          r_valid;
  logic [11:0]   r_addr;
  logic [DW-1:0] r_data;
  logic          r_err;

  logic          w_sel_l0;
  logic          w_sel_l1;
  logic          w_sel_ok;
  logic          w_in_dump;
  logic          w_wr_inrange;
  logic          w_rd_inrange;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_cpu_err;
  logic          w_dsel_ok;
  logic          w_start_req;
  logic          w_start_ok;
  logic          w_start_bad;
  logic          w_abort;
  logic          w_accept;
  logic          w_last_acc;
  logic [11:0]   w_last_addr;
  logic [11:0]   w_addr_nxt;

  // CPU port decode; out-of-range addresses are dropped rather than aliased
  assign w_sel_l0  = (csel == SEL_L0);
  assign w_sel_l1  = (csel == SEL_L1);
  assign w_sel_ok  = w_sel_l0 || w_sel_l1;
  assign w_in_dump = (r_state == DUMP);

  assign w_wr_inrange = w_sel_l1 ? ({1'b0, caddr_wr} < 13'(L1_DEPTH))
                                 : ({1'b0, caddr_wr} < 13'(L0_DEPTH));
  assign w_rd_inrange = w_sel_l1 ? ({1'b0, caddr_rd} < 13'(L1_DEPTH))
                                 : ({1'b0, caddr_rd} < 13'(L0_DEPTH));

  assign w_wr_en = cwr && w_sel_ok && w_wr_inrange && !w_in_dump;
  assign w_rd_en = crd && w_sel_ok && w_rd_inrange && !w_in_dump && reset;

  assign w_cpu_err = (cwr || crd) &&
                     (w_in_dump || !w_sel_ok || (cwr && !w_wr_inrange) || (crd && !w_rd_inrange));

  always_comb begin
    cdata_rd = '0;
    if (w_rd_en) begin
      cdata_rd = w_sel_l1 ? r_l1[caddr_rd[AW1-1:0]] : r_l0[caddr_rd[AW0-1:0]];
    end
  end

  // Bank contents survive reset
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      if (w_sel_l1) begin
        r_l1[caddr_wr[AW1-1:0]] <= cdata_wr;
      end else begin
        r_l0[caddr_wr[AW0-1:0]] <= cdata_wr;
      end
    end
  end

  assign w_dsel_ok   = (dump_sel == SEL_L0) || (dump_sel == SEL_L1);
  assign w_start_req = (r_state == IDLE) && dump_start && !busy;
  assign w_start_ok  = w_start_req && w_dsel_ok;
  assign w_start_bad = w_start_req && !w_dsel_ok;
  assign w_abort     = w_in_dump && busy;
  assign w_accept    = w_in_dump && r_valid && dump_ready && !busy;
  assign w_last_addr = r_dsel_l1 ? 12'(L1_DEPTH - 1) : 12'(L0_DEPTH - 1);
  assign w_last_acc  = w_accept && (r_addr == w_last_addr);
  assign w_addr_nxt  = r_addr + 12'd1;

  always_comb begin
    w_state_nxt = r_state;
    dump_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_state_nxt = DUMP;
      end
      DUMP: begin
        if (w_abort) begin
          w_state_nxt = IDLE;
        end else if (w_last_acc) begin
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        dump_done   = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_dsel_l1 <= 1'b0;
      r_valid   <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start_ok) begin
        r_dsel_l1 <= (dump_sel == SEL_L1);
        r_addr    <= '0;
        r_data    <= (dump_sel == SEL_L1) ? r_l1[0] : r_l0[0];
        r_valid   <= 1'b1;
      end else if (w_abort) begin
        r_valid <= 1'b0;
      end else if (w_accept) begin
        if (w_last_acc) begin
          r_valid <= 1'b0;
        end else begin
          // Prefetch the next word on acceptance so the stream has no bubble
          r_addr <= w_addr_nxt;
          r_data <= r_dsel_l1 ? r_l1[w_addr_nxt[AW1-1:0]] : r_l0[w_addr_nxt[AW0-1:0]];
        end
      end
      if (w_cpu_err || w_start_bad || w_abort) begin
        r_err <= 1'b1;
      end
    end
  end

  assign dump_valid = r_valid;
  assign dump_addr  = r_addr;
  assign dump_data  = r_data;
  assign err        = r_err;

endmodule
